maxnet_ctrl: RTL and testbench

Sequencing controller for the Maxnet winner-take-all datapath. After a `start` pulse it loads the initial activations. It then repeatedly commits inhibition updates until at most one neuron stays positive, or until an iteration limit is reached. It reports the winner and returns `ready`. The block sits between the top-level start/ready handshake and the Maxnet activation registers and inhibition arithmetic. It owns only control: it never touches activation values, only per-neuron nonzero flags from the datapath.

---
 rtl/maxnet_ctrl.sv | 107 ++++++++++
 tb/tb_maxnet_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_ctrl.sv
// Maxnet winner-take-all sequencing controller: loads activations, iterates
// inhibition updates until at most one neuron survives or the limit is hit.
module maxnet_ctrl #(
   parameter int N        = 4,
   parameter int MAX_ITER = 31,
   parameter int ITER_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N-1:0]      nz,
   output logic              ready,
   output logic              busy,
   output logic              sel_init,
   output logic              reg_we,
   output logic [N-1:0]      winner,
   output logic              winner_valid,
   output logic              timeout,
   output logic [ITER_W-1:0] iter_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_EVAL,
      S_UPDATE,
      S_DONE
   } state_t;

   state_t state;

   // Clearing the lowest set bit leaves a nonzero value only when two or more bits are set.
   logic multi;
   logic single;

   assign multi  = (nz & (nz - N'(1))) != '0;
   assign single = (nz != '0) && !multi;

   // Moore outputs are registered alongside the state so they change only with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         ready        <= 1'b1;
         busy         <= 1'b0;
         sel_init     <= 1'b0;
         reg_we       <= 1'b0;
         winner       <= '0;
         winner_valid <= 1'b0;
         timeout      <= 1'b0;
         iter_cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state        <= S_LOAD;
                  ready        <= 1'b0;
                  busy         <= 1'b1;
                  sel_init     <= 1'b1;
                  reg_we       <= 1'b1;
                  iter_cnt     <= '0;
                  winner       <= '0;
                  winner_valid <= 1'b0;
                  timeout      <= 1'b0;
               end
            end
            S_LOAD: begin
               state    <= S_EVAL;
               sel_init <= 1'b0;
               reg_we   <= 1'b0;
            end
            S_EVAL: begin
               if (!multi) begin
                  state        <= S_DONE;
                  winner       <= nz;
                  winner_valid <= single;
               end else if (iter_cnt == ITER_W'(MAX_ITER)) begin
                  state        <= S_DONE;
                  winner       <= nz;
                  winner_valid <= 1'b0;
                  timeout      <= 1'b1;
               end else begin
                  state  <= S_UPDATE;
                  reg_we <= 1'b1;
               end
            end
            S_UPDATE: begin
               state    <= S_EVAL;
               reg_we   <= 1'b0;
               iter_cnt <= iter_cnt + ITER_W'(1);
            end
            S_DONE: begin
               state <= S_IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
            end
            default: begin
               state    <= S_IDLE;
               ready    <= 1'b1;
               busy     <= 1'b0;
               sel_init <= 1'b0;
               reg_we   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Self-checking bench for maxnet_ctrl: a behavioural datapath model supplies nz,
// expected run results are queued at start and popped when ready returns.
module tb_maxnet_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       start_a = 1'b0;
   logic [3:0] nz_a;
   logic       ready_a, busy_a, sel_init_a, reg_we_a, valid_a, timeout_a;
   logic [3:0] winner_a;
   logic [4:0] iter_a;

   logic       start_b = 1'b0;
   logic [3:0] nz_b = 4'b0011;
   logic       ready_b, busy_b, sel_init_b, reg_we_b, valid_b, timeout_b;
   logic [3:0] winner_b;
   logic [1:0] iter_b;

   int vectors    = 0;
   int miscompares = 0;

   typedef struct {
      logic [3:0] w;
      logic       v;
      logic       t;
      logic [4:0] it;
      int         lat;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   maxnet_ctrl #(.N(4), .MAX_ITER(31), .ITER_W(5)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .nz(nz_a),
      .ready(ready_a), .busy(busy_a), .sel_init(sel_init_a), .reg_we(reg_we_a),
      .winner(winner_a), .winner_valid(valid_a), .timeout(timeout_a), .iter_cnt(iter_a)
   );

   maxnet_ctrl #(.N(4), .MAX_ITER(3), .ITER_W(2)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .nz(nz_b),
      .ready(ready_b), .busy(busy_b), .sel_init(sel_init_b), .reg_we(reg_we_b),
      .winner(winner_b), .winner_valid(valid_b), .timeout(timeout_b), .iter_cnt(iter_b)
   );

   // Datapath model: each update write advances to the next activation snapshot.
   logic [3:0] seq_a [16];
   logic [3:0] idx_a;
   int loads_a = 0, upds_a = 0, upds_b = 0;

   assign nz_a = seq_a[idx_a];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_a <= '0;
      end else if (reg_we_a) begin
         if (sel_init_a) begin
            idx_a   <= '0;
            loads_a <= loads_a + 1;
         end else begin
            idx_a  <= (idx_a < 4'd15) ? idx_a + 4'd1 : 4'd15;
            upds_a <= upds_a + 1;
         end
      end
   end

   always @(posedge clk) begin
      if (rst && reg_we_b && !sel_init_b) upds_b <= upds_b + 1;
   end

   task automatic load_seq(input logic [3:0] s0, s1, s2, s3);
      seq_a[0] = s0;
      seq_a[1] = s1;
      seq_a[2] = s2;
      for (int i = 3; i < 16; i++) seq_a[i] = s3;
   endtask

   task automatic run_a(input logic [3:0] s0, s1, s2, s3, input logic [3:0] ew,
                        input logic ev, et, input int k, input int pulse_at);
      exp_t e;
      int cyc, l0, u0;
      load_seq(s0, s1, s2, s3);
      e = '{ew, ev, et, 5'(k), 3 + 2 * k};
      sb.push_back(e);
      @(negedge clk);
      l0 = loads_a;
      u0 = upds_a;
      start_a = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         start_a = (cyc == pulse_at);
      end while (!ready_a && cyc < 200);
      start_a = 1'b0;
      e = sb.pop_front();
      vectors++;
      if (ready_a !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_wait: ready=%b after %0d cycles, expected 1", ready_a, cyc);
      end
      vectors++;
      if (cyc - 1 !== e.lat) begin
         miscompares++;
         $display("FAIL latency: got %0d expected %0d", cyc - 1, e.lat);
      end
      vectors++;
      if (winner_a !== e.w) begin
         miscompares++;
         $display("FAIL winner: got %b expected %b", winner_a, e.w);
      end
      vectors++;
      if (valid_a !== e.v) begin
         miscompares++;
         $display("FAIL winner_valid: got %b expected %b", valid_a, e.v);
      end
      vectors++;
      if (timeout_a !== e.t) begin
         miscompares++;
         $display("FAIL timeout: got %b expected %b", timeout_a, e.t);
      end
      vectors++;
      if (iter_a !== e.it) begin
         miscompares++;
         $display("FAIL iter_cnt: got %0d expected %0d", iter_a, e.it);
      end
      vectors++;
      if (loads_a - l0 !== 1) begin
         miscompares++;
         $display("FAIL load_writes: got %0d expected 1", loads_a - l0);
      end
      vectors++;
      if (upds_a - u0 !== k) begin
         miscompares++;
         $display("FAIL update_writes: got %0d expected %0d", upds_a - u0, k);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      vectors++;
      if ({ready_a, busy_a, sel_init_a, reg_we_a} !== 4'b1000) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b expected 1000", {ready_a, busy_a, sel_init_a, reg_we_a});
      end
      vectors++;
      if ({winner_a, valid_a, timeout_a, iter_a} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_results: got %h expected 0", {winner_a, valid_a, timeout_a, iter_a});
      end
      vectors++;
      if ({ready_b, busy_b, reg_we_b, iter_b} !== 5'b10000) begin
         miscompares++;
         $display("FAIL reset_b: got %b expected 10000", {ready_b, busy_b, reg_we_b, iter_b});
      end
   endtask

   task automatic test_immediate;
      run_a(4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 0, -1);
   endtask

   task automatic test_multi_iter;
      run_a(4'b1111, 4'b0111, 4'b0110, 4'b0100, 4'b0100, 1'b1, 1'b0, 3, -1);
   endtask

   task automatic test_annihilation;
      int l0;
      // start pulse lands in the UPDATE cycle (third cycle after the accepted start)
      run_a(4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1, 3);
      l0 = loads_a;
      repeat (5) @(negedge clk);
      vectors++;
      if (loads_a !== l0 || ready_a !== 1'b1) begin
         miscompares++;
         $display("FAIL ignored_start: extra loads=%0d ready=%b expected 0 and 1", loads_a - l0, ready_a);
      end
   endtask

   task automatic test_timeout;
      int cyc, u0;
      @(negedge clk);
      u0 = upds_b;
      start_b = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         start_b = 1'b0;
      end while (!ready_b && cyc < 200);
      vectors++;
      if (cyc - 1 !== 9) begin
         miscompares++;
         $display("FAIL timeout_latency: got %0d expected 9", cyc - 1);
      end
      vectors++;
      if ({timeout_b, valid_b, winner_b, iter_b} !== {1'b1, 1'b0, 4'b0011, 2'd3}) begin
         miscompares++;
         $display("FAIL timeout_result: got t=%b v=%b w=%b it=%0d expected t=1 v=0 w=0011 it=3",
                  timeout_b, valid_b, winner_b, iter_b);
      end
      vectors++;
      if (upds_b - u0 !== 3) begin
         miscompares++;
         $display("FAIL timeout_updates: got %0d expected 3", upds_b - u0);
      end
   endtask

   task automatic test_reset_midrun;
      int cyc;
      load_seq(4'b1111, 4'b1110, 4'b1100, 4'b1000);
      @(negedge clk);
      start_a = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         start_a = 1'b0;
      end while (cyc < 5);
      #2 rst = 1'b0;
      #1;
      vectors++;
      if ({ready_a, busy_a, reg_we_a, sel_init_a} !== 4'b1000) begin
         miscompares++;
         $display("FAIL async_reset_ctrl: got %b expected 1000", {ready_a, busy_a, reg_we_a, sel_init_a});
      end
      vectors++;
      if ({iter_a, winner_a, valid_a, timeout_a} !== 11'd0) begin
         miscompares++;
         $display("FAIL async_reset_results: got %h expected 0", {iter_a, winner_a, valid_a, timeout_a});
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      run_a(4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b1000, 1'b1, 1'b0, 3, -1);
   endtask

   initial begin
      load_seq(4'b0000, 4'b0000, 4'b0000, 4'b0000);
      test_reset();
      test_immediate();
      test_multi_iter();
      test_annihilation();
      test_timeout();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
